if_fetch: RTL



---
 rtl/if_fetch_pkg.sv | 26 ++
 rtl/if_btb.sv | 68 ++++++
 rtl/if_fetch.sv | 118 +++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: widths, stall/flush levels and IF state encodings.
// Consumed by if_fetch and by the optional BPRED_EN branch predictor (if_btb).
package if_fetch_pkg;

  localparam int AddrLen       = 32;
  localparam int InstLen       = 32;
  localparam int PipelineDepth = 6;

  localparam logic StallEnable  = 1'b1;
  localparam logic StallDisable = 1'b0;
  localparam logic FlushEnable  = 1'b1;
  localparam logic FlushDisable = 1'b0;

  localparam logic [AddrLen-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_t;

  function automatic logic [AddrLen-1:0] word_align(input logic [AddrLen-1:0] a);
    return {a[AddrLen-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Only instantiated when BPRED_EN is defined; lookup reads pre-update contents.
module if_btb
  import if_fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AddrLen-1:0] lookup_pc,
  output logic [AddrLen-1:0] pred,
  input  logic               upd_valid,
  input  logic [AddrLen-1:0] upd_pc,
  input  logic [AddrLen-1:0] upd_target,
  input  logic               upd_taken
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = AddrLen - 2 - IW;

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tag    [ENTRIES];
  logic [AddrLen-1:0] target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];

  logic [IW-1:0] l_idx, u_idx;
  logic [TW-1:0] l_tag, u_tag;
  logic          l_hit, u_hit;
  logic          unused_ok;

  assign l_idx = lookup_pc[2+IW-1:2];
  assign l_tag = lookup_pc[AddrLen-1:2+IW];
  assign u_idx = upd_pc[2+IW-1:2];
  assign u_tag = upd_pc[AddrLen-1:2+IW];
  assign l_hit = valid[l_idx] && (tag[l_idx] == l_tag);
  assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

  // counter >= 2 means predict taken
  assign pred = (l_hit && ctr[l_idx][1]) ? target[l_idx] : lookup_pc + 32'd4;

  assign unused_ok = ^{lookup_pc[1:0], upd_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          if (ctr[u_idx] != 2'd3) ctr[u_idx] <= ctr[u_idx] + 2'd1;
          target[u_idx] <= upd_target;
        end else if (ctr[u_idx] != 2'd0) begin
          ctr[u_idx] <= ctr[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= u_tag;
        target[u_idx] <= upd_target;
        ctr[u_idx]    <= 2'd2;
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: byte-serial fetch of one word, little-endian assembly, hold for IF/ID.
// Define BPRED_EN to predict the next PC from a BTB (if_btb); otherwise pred = pc + 4.
//
// state    | meaning
// IF_IDLE  | one-cycle gap, mem_req low; cancels any in-flight access
// IF_FETCH | mem_req high, collecting 4 bytes
// IF_HOLD  | instruction presented to IF/ID until stall[0] drops
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [AddrLen-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                 BTB_ENTRIES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PipelineDepth-1:0] stall,
  input  logic                     flush,
  input  logic [AddrLen-1:0]       branch_target,
  output logic                     mem_req,
  output logic [AddrLen-1:0]       mem_addr,
  input  logic [7:0]               mem_byte,
  input  logic                     mem_byte_valid,
  output logic [AddrLen-1:0]       if_pc,
  output logic [InstLen-1:0]       if_inst,
  output logic [AddrLen-1:0]       if_prediction,
  output logic                     if_stall_req,
  input  logic                     upd_valid,
  input  logic [AddrLen-1:0]       upd_pc,
  input  logic [AddrLen-1:0]       upd_target,
  input  logic                     upd_taken
);

  if_state_t          state, state_nxt;
  logic [AddrLen-1:0] pc, pred;
  logic [1:0]         cnt;
  logic [InstLen-1:0] ibuf;
  logic               advance, capture;
  logic               unused_ok;

  assign advance  = (state == IF_HOLD) && (stall[0] == StallDisable);
  assign capture  = (state == IF_FETCH) && mem_byte_valid;
  assign mem_addr = pc;

`ifdef BPRED_EN
  if_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc),
    .pred       (pred),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken)
  );
  assign unused_ok = ^{stall[PipelineDepth-1:1], branch_target[1:0]};
`else
  assign pred      = pc + 32'd4;
  assign unused_ok = ^{stall[PipelineDepth-1:1], branch_target[1:0],
                       upd_valid, upd_pc, upd_target, upd_taken};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IF_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush == FlushEnable) begin
      state_nxt = IF_IDLE;
    end else begin
      case (state)
        IF_IDLE:  state_nxt = IF_FETCH;
        IF_FETCH: if (capture && cnt == 2'd3) state_nxt = IF_HOLD;
        IF_HOLD:  if (advance) state_nxt = IF_IDLE;
        default:  state_nxt = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc   <= word_align(RESET_PC);
      cnt  <= 2'd0;
      ibuf <= ZERO_WORD;
    end else if (flush == FlushEnable) begin
      pc  <= word_align(branch_target);
      cnt <= 2'd0;
    end else begin
      if (state == IF_IDLE) cnt <= 2'd0;
      if (capture) begin
        for (int i = 0; i < 4; i++)
          if (cnt == i[1:0]) ibuf[8*i +: 8] <= mem_byte;
        cnt <= cnt + 2'd1;
      end
      if (advance) pc <= word_align(pred);
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    if_stall_req  = 1'b1;
    if_pc         = ZERO_WORD;
    if_inst       = ZERO_WORD;
    if_prediction = ZERO_WORD;
    case (state)
      IF_FETCH: mem_req = 1'b1;
      IF_HOLD: begin
        if_stall_req  = 1'b0;
        if_pc         = pc;
        if_inst       = ibuf;
        if_prediction = pred;
      end
      default: ;
    endcase
  end

endmodule
